// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the icache (port 0) and
// the dcache (port 1). One block transaction at a time; the grant is held until
// the memory returns ready, with a response watchdog that flags a hung memory.
//
// Optional feature macro: DMEM_ARB_RR_EN
//   defined     -> round-robin arbitration under contention
//   not defined -> fixed priority, dcache (port 1) wins contention
module dmem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic         clock,
  input  logic         reset,
  // port 0 (icache) request / response
  input  logic         ic_req_valid,
  input  logic         ic_req_rw,
  input  logic [31:0]  ic_req_addr,
  input  logic [127:0] ic_req_data,
  output logic         ic_resp_ready,
  output logic [127:0] ic_resp_data,
  // port 1 (dcache) request / response
  input  logic         dc_req_valid,
  input  logic         dc_req_rw,
  input  logic [31:0]  dc_req_addr,
  input  logic [127:0] dc_req_data,
  output logic         dc_resp_ready,
  output logic [127:0] dc_resp_data,
  // memory side
  output logic         mem_req_valid,
  output logic         mem_req_rw,
  output logic [31:0]  mem_req_addr,
  output logic [127:0] mem_req_data,
  input  logic         mem_data_ready,
  input  logic [127:0] mem_data_data,
  // status
  output logic         busy,
  output logic         grant_id,
  output logic         arb_error
);

  typedef enum logic {StIdle, StBusy} state_e;

  localparam logic [7:0] WdLimit = 8'(TIMEOUT_CYCLES - 1);

  state_e     state_q;
  // grant_id and last_grant are always loaded together with the same value,
  // so a single flop carries both.
  logic       last_grant_q;
  logic [7:0] wd_count_q;
  logic       arb_error_q;
  logic       winner;

  // Pick the winner among the ports requesting in IDLE
  always_comb begin
    winner = dc_req_valid;
`ifdef DMEM_ARB_RR_EN
    if (ic_req_valid && dc_req_valid) begin
      winner = ~last_grant_q;
    end
`endif
  end

  // Arbiter FSM with grant register and response watchdog
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b0;
      wd_count_q   <= 8'd0;
      arb_error_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ic_req_valid || dc_req_valid) begin
            state_q      <= StBusy;
            last_grant_q <= winner;
            wd_count_q   <= 8'd0;
          end
        end
        StBusy: begin
          // ready beats a coincident timeout
          if (mem_data_ready) begin
            state_q <= StIdle;
          end else if (wd_count_q == WdLimit) begin
            arb_error_q <= 1'b1;
            state_q     <= StIdle;
          end else begin
            wd_count_q <= wd_count_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Live request pass-through and same-cycle response steering while BUSY
  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = 32'd0;
    mem_req_data  = 128'd0;
    ic_resp_ready = 1'b0;
    ic_resp_data  = 128'd0;
    dc_resp_ready = 1'b0;
    dc_resp_data  = 128'd0;
    if (state_q == StBusy) begin
      if (last_grant_q) begin
        mem_req_valid = dc_req_valid;
        mem_req_rw    = dc_req_rw;
        mem_req_addr  = dc_req_addr;
        mem_req_data  = dc_req_data;
        if (mem_data_ready) begin
          dc_resp_ready = 1'b1;
          dc_resp_data  = mem_data_data;
        end
      end else begin
        mem_req_valid = ic_req_valid;
        mem_req_rw    = ic_req_rw;
        mem_req_addr  = ic_req_addr;
        mem_req_data  = ic_req_data;
        if (mem_data_ready) begin
          ic_resp_ready = 1'b1;
          ic_resp_data  = mem_data_data;
        end
      end
    end
  end

  assign busy      = (state_q == StBusy);
  assign grant_id  = last_grant_q;
  assign arb_error = arb_error_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: two behavioural requesters, a behavioural
// memory with random latency (including stalls past the watchdog), spurious
// ready pulses in IDLE and asynchronous resets in the middle of transactions.
module tb_dmem_arbiter;

  localparam int unsigned Timeout = 8;
  localparam int unsigned NumCycles = 4000;
`ifdef DMEM_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic         clock;
  logic         reset;
  logic         ic_req_valid, ic_req_rw, dc_req_valid, dc_req_rw;
  logic [31:0]  ic_req_addr, dc_req_addr;
  logic [127:0] ic_req_data, dc_req_data;
  logic         ic_resp_ready, dc_resp_ready;
  logic [127:0] ic_resp_data, dc_resp_data;
  logic         mem_req_valid, mem_req_rw;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_data_ready;
  logic [127:0] mem_data_data;
  logic         busy, grant_id, arb_error;

  dmem_arbiter #(.TIMEOUT_CYCLES(Timeout)) dut (
    .clock         (clock),
    .reset         (reset),
    .ic_req_valid  (ic_req_valid),
    .ic_req_rw     (ic_req_rw),
    .ic_req_addr   (ic_req_addr),
    .ic_req_data   (ic_req_data),
    .ic_resp_ready (ic_resp_ready),
    .ic_resp_data  (ic_resp_data),
    .dc_req_valid  (dc_req_valid),
    .dc_req_rw     (dc_req_rw),
    .dc_req_addr   (dc_req_addr),
    .dc_req_data   (dc_req_data),
    .dc_resp_ready (dc_resp_ready),
    .dc_resp_data  (dc_resp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_rw    (mem_req_rw),
    .mem_req_addr  (mem_req_addr),
    .mem_req_data  (mem_req_data),
    .mem_data_ready(mem_data_ready),
    .mem_data_data (mem_data_data),
    .busy          (busy),
    .grant_id      (grant_id),
    .arb_error     (arb_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the memory, for how long, sticky error, last grant
  bit m_busy, m_last, m_err;
  int m_age;

  // Requesters: one outstanding request each, held until it completes
  logic         r_valid [2];
  logic         r_rw    [2];
  logic [31:0]  r_addr  [2];
  logic [127:0] r_data  [2];
  int           r_gap   [2];

  // Memory: block store plus per-transaction latency
  logic [127:0] store [logic [31:0]];
  int           mem_cnt, mem_lat;
  bit           cur_sees, cur_ready;
  logic [127:0] cur_mdata;
  bit           did_busy3_reset;

  function automatic logic [127:0] mem_read(input logic [31:0] a);
    if (store.exists(a)) return store[a];
    return {a ^ 32'hA5A5_0000, ~a, a, 32'h0BAD_F00D};
  endfunction

  task automatic drive_pins();
    ic_req_valid   = r_valid[0];
    ic_req_rw      = r_rw[0];
    ic_req_addr    = r_addr[0];
    ic_req_data    = r_data[0];
    dc_req_valid   = r_valid[1];
    dc_req_rw      = r_rw[1];
    dc_req_addr    = r_addr[1];
    dc_req_data    = r_data[1];
    mem_data_ready = cur_ready;
    mem_data_data  = cur_mdata;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".mem_req"}, {mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data}, '0);
    check_eq({tag, ".ic_resp"}, {ic_resp_ready, ic_resp_data}, '0);
    check_eq({tag, ".dc_resp"}, {dc_resp_ready, dc_resp_data}, '0);
    check_eq({tag, ".status"}, {busy, grant_id, arb_error}, '0);
  endtask

  // Asynchronous reset pulse; called at posedge+1 with the current inputs applied
  task automatic reset_pulse();
    cur_ready = 1'b1;
    cur_mdata = {$urandom, $urandom, $urandom, $urandom};
    drive_pins();
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(posedge clock);
    #1;
    reset  = 1'b0;
    m_busy = 1'b0;
    m_last = 1'b0;
    m_err  = 1'b0;
    m_age  = 0;
    mem_cnt = 0;
  endtask

  initial begin
    bit ic_v, dc_v, win;
    logic [127:0] exp_rd;
    for (int p = 0; p < 2; p++) begin
      r_valid[p] = 1'b0;
      r_rw[p]    = 1'b0;
      r_addr[p]  = 32'd0;
      r_data[p]  = 128'd0;
      r_gap[p]   = 0;
    end
    cur_ready = 1'b0;
    cur_mdata = 128'd0;
    mem_cnt = 0;
    mem_lat = 0;
    did_busy3_reset = 1'b0;
    m_busy = 1'b0; m_last = 1'b0; m_err = 1'b0; m_age = 0;
    drive_pins();
    reset = 1'b1;
    #12;
    check_all_zero("reset_state");
    @(posedge clock);
    #1;
    reset = 1'b0;

    for (int cyc = 0; cyc < NumCycles; cyc++) begin
      // Phase A: requesters and memory choose this cycle's inputs
      for (int p = 0; p < 2; p++) begin
        if (!r_valid[p]) begin
          if (r_gap[p] > 0) r_gap[p]--;
          else if ($urandom_range(0, 2) != 0) begin
            r_valid[p] = 1'b1;
            r_rw[p]    = $urandom_range(0, 1) == 1;
            r_addr[p]  = 32'h100 + 32'($urandom_range(0, 7)) * 32'h10;
            r_data[p]  = {$urandom, $urandom, $urandom, $urandom};
          end
        end
      end
      cur_sees = m_busy && r_valid[m_last];
      if (cur_sees) begin
        if (mem_cnt == 0) mem_lat = ($urandom_range(0, 9) == 0) ? 40 : $urandom_range(0, 8);
        cur_ready = (mem_cnt == mem_lat);
        cur_mdata = (cur_ready && !r_rw[m_last]) ? mem_read(r_addr[m_last]) : 128'd0;
      end else begin
        cur_ready = ($urandom_range(0, 7) == 0);
        cur_mdata = cur_ready ? {$urandom, $urandom, $urandom, $urandom} : 128'd0;
      end

      if (m_busy && m_age == 2 && !did_busy3_reset) begin
        did_busy3_reset = 1'b1;
        reset_pulse();
        continue;
      end
      if (m_busy && $urandom_range(0, 199) == 0) begin
        reset_pulse();
        continue;
      end
      drive_pins();

      // Phase B: compare outputs against the model
      @(negedge clock);
      check_eq("status", {busy, grant_id, arb_error}, {m_busy, m_last, m_err});
      if (m_busy) begin
        check_eq("mem_req", {mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data},
                 {r_valid[m_last], r_rw[m_last], r_addr[m_last], r_data[m_last]});
      end else begin
        check_eq("mem_req_idle", {mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data}, '0);
      end
      exp_rd = (m_busy && cur_ready) ? cur_mdata : 128'd0;
      check_eq("ic_resp", {ic_resp_ready, ic_resp_data},
               (m_busy && cur_ready && m_last == 1'b0) ? {1'b1, exp_rd} : 129'd0);
      check_eq("dc_resp", {dc_resp_ready, dc_resp_data},
               (m_busy && cur_ready && m_last == 1'b1) ? {1'b1, exp_rd} : 129'd0);

      // Phase C: advance the model across the clock edge
      @(posedge clock);
      ic_v = r_valid[0];
      dc_v = r_valid[1];
      if (!m_busy) begin
        if (ic_v || dc_v) begin
          if (ic_v && dc_v) win = RrEn ? !m_last : 1'b1;
          else win = dc_v;
          m_busy = 1'b1;
          m_last = win;
          m_age  = 0;
        end
      end else if (cur_ready) begin
        if (r_rw[m_last]) store[r_addr[m_last]] = r_data[m_last];
        r_valid[m_last] = 1'b0;
        r_gap[m_last]   = $urandom_range(0, 2);
        m_busy = 1'b0;
      end else if (m_age == int'(Timeout) - 1) begin
        m_err  = 1'b1;
        m_busy = 1'b0;
      end else begin
        m_age++;
      end
      if (cur_sees && !cur_ready) mem_cnt++;
      else mem_cnt = 0;
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
